// File: rtl/lane_region_filler_pkg.sv
// Shared screen constants, lane geometry defaults and the filler state encoding.
// Also imported by the obstacle and player renderers, so geometry stays consistent.
package lane_region_filler_pkg;

  localparam int XSCREEN = 640;
  localparam int YSCREEN = 480;
  localparam int X_BITS  = 10;
  localparam int Y_BITS  = 9;

  localparam int COLOR_BITS_DEF = 9;
  localparam logic [COLOR_BITS_DEF-1:0] BLACK = '0;

  localparam int NUM_LANES_DEF    = 5;
  localparam int LANE_START_X_DEF = 120;
  localparam int LANE_PITCH_DEF   = 80;
  localparam int LANE_INSET_DEF   = 10;
  localparam int FILL_WIDTH_DEF   = 60;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEEK   = 2'd1,
    FILL   = 2'd2,
    FINISH = 2'd3
  } fill_state_t;

  function automatic int lane_first_col(input int lane, input int start_x,
                                        input int pitch, input int inset);
    return start_x + lane * pitch + inset;
  endfunction

endpackage

// File: rtl/lane_region_filler_scan_counter.sv
// lane_scan_counter: xoff-fastest / y-slower nested raster counter for one lane strip.
// Exposes the next-cycle values so the parent can register pixel coordinates directly.
module lane_scan_counter
  import lane_region_filler_pkg::*;
#(
  parameter int FILL_WIDTH = FILL_WIDTH_DEF,
  parameter int Y_START    = 0,
  parameter int Y_END      = YSCREEN - 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              load,
  input  logic              en,
  output logic [X_BITS-1:0] xoff_nxt,
  output logic [Y_BITS-1:0] y_nxt,
  output logic              last_pixel
);

  logic [X_BITS-1:0] xoff_q;
  logic [Y_BITS-1:0] y_q;
  logic              x_wrap;

  assign x_wrap     = (xoff_q == X_BITS'(FILL_WIDTH - 1));
  assign last_pixel = x_wrap && (y_q == Y_BITS'(Y_END));

  always_comb begin
    xoff_nxt = xoff_q;
    y_nxt    = y_q;
    if (load) begin
      xoff_nxt = '0;
      y_nxt    = Y_BITS'(Y_START);
    end else if (en) begin
      if (x_wrap) begin
        xoff_nxt = '0;
        y_nxt    = (y_q == Y_BITS'(Y_END)) ? Y_BITS'(Y_START) : y_q + Y_BITS'(1);
      end else begin
        xoff_nxt = xoff_q + X_BITS'(1);
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      xoff_q <= '0;
      y_q    <= '0;
    end else begin
      xoff_q <= xoff_nxt;
      y_q    <= y_nxt;
    end
  end

endmodule

// File: rtl/lane_region_filler.sv
// Fills a run-time subset of lane strips with a colour, streaming pixels over valid/ready.
// Optional LANE_FILLER_AUTOSTART_EN: self-start (all lanes, black) on the first edge after reset.
//
// state  | meaning
// IDLE   | waiting for start; outputs quiet
// SEEK   | stepping lane index, one lane per cycle, looking for the next enabled lane
// FILL   | offering pixels of the current lane; advances on valid && ready
// FINISH | one-cycle done pulse, busy already low
module lane_region_filler
  import lane_region_filler_pkg::*;
#(
  parameter int NUM_LANES    = NUM_LANES_DEF,
  parameter int LANE_START_X = LANE_START_X_DEF,
  parameter int LANE_PITCH   = LANE_PITCH_DEF,
  parameter int LANE_INSET   = LANE_INSET_DEF,
  parameter int FILL_WIDTH   = FILL_WIDTH_DEF,
  parameter int Y_START      = 0,
  parameter int Y_END        = YSCREEN - 1,
  parameter int COLOR_BITS   = COLOR_BITS_DEF
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  start,
  input  logic [NUM_LANES-1:0]  lane_mask,
  input  logic [COLOR_BITS-1:0] fill_color,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [X_BITS-1:0]     pix_x,
  output logic [Y_BITS-1:0]     pix_y,
  output logic [COLOR_BITS-1:0] pix_color,
  output logic                  pix_valid,
  input  logic                  pix_ready
);

  localparam int LANE_W   = $clog2(NUM_LANES + 1);
  localparam int MASK_EXT = 1 << LANE_W;
  localparam int LAST_COL = lane_first_col(NUM_LANES - 1, LANE_START_X, LANE_PITCH, LANE_INSET)
                            + FILL_WIDTH - 1;

  if (LAST_COL >= XSCREEN) begin : g_col_check
    $error("lane_region_filler: last filled column %0d is beyond the screen", LAST_COL);
  end
  if (Y_END < Y_START || Y_END >= YSCREEN) begin : g_row_check
    $error("lane_region_filler: bad row range %0d..%0d", Y_START, Y_END);
  end

  fill_state_t             state_q, state_nxt;
  logic [LANE_W-1:0]       lane_q, lane_nxt;
  logic [NUM_LANES-1:0]    mask_q;
  logic [COLOR_BITS-1:0]   color_q;
  logic [MASK_EXT-1:0]     mask_ext;
  logic [X_BITS-1:0]       lane_base;
  logic                    take_start, cnt_load, cnt_en, hs;
  logic                    start_eff;
  logic [NUM_LANES-1:0]    mask_in;
  logic [COLOR_BITS-1:0]   color_in;
  logic [X_BITS-1:0]       xoff_nxt;
  logic [Y_BITS-1:0]       y_nxt;
  logic                    last_pixel;

`ifdef LANE_FILLER_AUTOSTART_EN
  // High only for the first edge after reset; overrides whatever start carries then.
  logic auto_pend_q;
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) auto_pend_q <= 1'b1;
    else       auto_pend_q <= 1'b0;
  end
  assign start_eff = start || auto_pend_q;
  assign mask_in   = auto_pend_q ? '1 : lane_mask;
  assign color_in  = auto_pend_q ? COLOR_BITS'(BLACK) : fill_color;
`else
  assign start_eff = start;
  assign mask_in   = lane_mask;
  assign color_in  = fill_color;
`endif

  assign mask_ext  = MASK_EXT'(mask_q);
  assign hs        = pix_valid && pix_ready;
  assign lane_base = X_BITS'(lane_first_col(int'(lane_q), LANE_START_X, LANE_PITCH, LANE_INSET));

  always_comb begin
    state_nxt  = state_q;
    lane_nxt   = lane_q;
    take_start = 1'b0;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_eff) begin
          take_start = 1'b1;
          lane_nxt   = '0;
          state_nxt  = SEEK;
        end
      end
      SEEK: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (lane_q == LANE_W'(NUM_LANES)) begin
          state_nxt = FINISH;
        end else if (mask_ext[lane_q]) begin
          cnt_load  = 1'b1;
          state_nxt = FILL;
        end else begin
          lane_nxt = lane_q + LANE_W'(1);
        end
      end
      FILL: begin
        cnt_en = hs;
        if (abort) begin
          state_nxt = IDLE;
        end else if (hs && last_pixel) begin
          lane_nxt  = lane_q + LANE_W'(1);
          state_nxt = SEEK;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      lane_q    <= '0;
      mask_q    <= '0;
      color_q   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_color <= '0;
    end else begin
      state_q   <= state_nxt;
      lane_q    <= lane_nxt;
      busy      <= (state_nxt == SEEK) || (state_nxt == FILL);
      done      <= (state_nxt == FINISH);
      pix_valid <= (state_nxt == FILL);
      if (take_start) begin
        mask_q  <= mask_in;
        color_q <= color_in;
      end
      // Coordinates only move on load or a non-final handshake, so they hold under back-pressure.
      if (cnt_load || (cnt_en && !last_pixel)) begin
        pix_x <= lane_base + xoff_nxt;
        pix_y <= y_nxt;
      end
      if (cnt_load) pix_color <= color_q;
    end
  end

  lane_scan_counter #(
    .FILL_WIDTH (FILL_WIDTH),
    .Y_START    (Y_START),
    .Y_END      (Y_END)
  ) u_scan (
    .Clock      (Clock),
    .Reset      (Reset),
    .load       (cnt_load),
    .en         (cnt_en),
    .xoff_nxt   (xoff_nxt),
    .y_nxt      (y_nxt),
    .last_pixel (last_pixel)
  );

endmodule

// File: tb/tb_lane_region_filler.sv
// Directed bench for lane_region_filler with a reduced row range (Y_END=11).
// Build with LANE_FILLER_AUTOSTART_EN to exercise the power-up self-start.
module tb_lane_region_filler;

  localparam int NL = 5;
  localparam int YE = 11;
  localparam int FW = 60;
  localparam int LANE_PIX = FW * (YE + 1);

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       pix_ready = 1'b1;
  logic [4:0] lane_mask = '0;
  logic [8:0] fill_color = '0;
  logic       busy, done, pix_valid;
  logic [9:0] pix_x;
  logic [8:0] pix_y;
  logic [8:0] pix_color;

  int n_cmp = 0;
  int n_err = 0;

  int w_npix, w_nbad, w_ndone, w_first_valid, w_done_cyc, w_extra_valid, w_last_x, w_last_y;
  bit w_timeout, w_valid_end;

  always #5 Clock = ~Clock;

  lane_region_filler #(.Y_END(YE)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .start      (start),
    .lane_mask  (lane_mask),
    .fill_color (fill_color),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_color  (pix_color),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready)
  );

  function automatic int next_lane(input logic [4:0] m, input int from);
    for (int i = from; i < NL; i++) if (m[i]) return i;
    return NL;
  endfunction

  // Runs one fill from a negedge, tracking the expected raster and recording observations.
  task automatic watch_fill(input logic [4:0] mask, input logic [8:0] color, input bit issue,
                            input bit rnd, input bit abort_with_start, input int abort_at,
                            input int restart_at);
    int lane, yy, xo, cyc;
    bit fin;
    w_npix = 0; w_nbad = 0; w_ndone = 0; w_extra_valid = 0;
    w_first_valid = -1; w_done_cyc = -1; w_last_x = -1; w_last_y = -1;
    w_timeout = 0; w_valid_end = 0;
    lane = next_lane(mask, 0); yy = 0; xo = 0;
    if (issue) begin
      start = 1'b1; lane_mask = mask; fill_color = color; abort = abort_with_start;
    end
    @(negedge Clock);
    start = 1'b0; abort = 1'b0;
    cyc = 1; fin = 0;
    while (!fin) begin
      if (restart_at >= 0 && w_npix == restart_at) begin
        start = 1'b1; lane_mask = ~mask; fill_color = ~color;
      end else begin
        start = 1'b0;
      end
      abort = 1'b0;
      if (done) begin
        w_ndone++;
        if (w_done_cyc < 0) w_done_cyc = cyc;
      end
      pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pix_valid) begin
        if (w_first_valid < 0) w_first_valid = cyc;
        if (lane >= NL || pix_x !== 10'(130 + lane * 80 + xo) || pix_y !== 9'(yy)
            || pix_color !== color)
          w_nbad++;
        if (pix_ready) begin
          w_last_x = int'(pix_x); w_last_y = int'(pix_y);
          w_npix++;
          if (w_npix == abort_at) abort = 1'b1;
          xo++;
          if (xo == FW) begin
            xo = 0; yy++;
            if (yy > YE) begin yy = 0; lane = next_lane(mask, lane + 1); end
          end
        end
      end
      if (!busy) begin
        fin = 1; w_valid_end = pix_valid;
      end else begin
        @(negedge Clock);
        cyc++;
        if (cyc > 40000) begin fin = 1; w_timeout = 1; end
      end
    end
    start = 1'b0; abort = 1'b0; pix_ready = 1'b1;
    repeat (4) begin
      @(negedge Clock);
      if (done) w_ndone++;
      if (pix_valid) w_extra_valid++;
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1; start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge Clock);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
    n_cmp++; if (pix_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", pix_valid); end
    n_cmp++; if (pix_x !== 10'd0) begin n_err++; $display("FAIL reset_x: got %0d expected 0", pix_x); end
    n_cmp++; if (pix_y !== 9'd0) begin n_err++; $display("FAIL reset_y: got %0d expected 0", pix_y); end
    n_cmp++; if (pix_color !== 9'd0) begin n_err++; $display("FAIL reset_color: got %h expected 0", pix_color); end
    Reset = 1'b0;
`ifndef LANE_FILLER_AUTOSTART_EN
    repeat (3) @(negedge Clock);
    n_cmp++; if (busy !== 1'b0 || pix_valid !== 1'b0) begin
      n_err++; $display("FAIL idle_after_reset: got busy=%b valid=%b expected 0 0", busy, pix_valid);
    end
`endif
  endtask

  task automatic test_full_fill;
    watch_fill(5'b11111, 9'h1FF, 1, 0, 0, -1, -1);
    n_cmp++; if (w_timeout) begin n_err++; $display("FAIL full_timeout: got timeout expected completion"); end
    n_cmp++; if (w_npix != NL * LANE_PIX) begin n_err++; $display("FAIL full_count: got %0d expected %0d", w_npix, NL * LANE_PIX); end
    n_cmp++; if (w_nbad != 0) begin n_err++; $display("FAIL full_sequence: got %0d bad pixels expected 0", w_nbad); end
    n_cmp++; if (w_first_valid != 2) begin n_err++; $display("FAIL full_first_valid: got cycle %0d expected 2", w_first_valid); end
    n_cmp++; if (w_last_x != 509 || w_last_y != YE) begin
      n_err++; $display("FAIL full_last_pixel: got (%0d,%0d) expected (509,%0d)", w_last_x, w_last_y, YE);
    end
    n_cmp++; if (w_ndone != 1) begin n_err++; $display("FAIL full_done: got %0d pulses expected 1", w_ndone); end
    n_cmp++; if (w_extra_valid != 0) begin n_err++; $display("FAIL full_idle_valid: got %0d expected 0", w_extra_valid); end
  endtask

  task automatic test_single_lane;
    watch_fill(5'b00100, 9'h0E0, 1, 0, 0, -1, 100);
    n_cmp++; if (w_npix != LANE_PIX) begin n_err++; $display("FAIL lane2_count: got %0d expected %0d", w_npix, LANE_PIX); end
    n_cmp++; if (w_nbad != 0) begin n_err++; $display("FAIL lane2_sequence: got %0d bad pixels expected 0", w_nbad); end
    n_cmp++; if (w_first_valid != 4) begin n_err++; $display("FAIL lane2_seek_latency: got cycle %0d expected 4", w_first_valid); end
    n_cmp++; if (w_last_x != 349 || w_last_y != YE) begin
      n_err++; $display("FAIL lane2_last_pixel: got (%0d,%0d) expected (349,%0d)", w_last_x, w_last_y, YE);
    end
    n_cmp++; if (w_ndone != 1) begin n_err++; $display("FAIL lane2_done: got %0d pulses expected 1", w_ndone); end
  endtask

  task automatic test_empty_mask;
    watch_fill(5'b00000, 9'h123, 1, 0, 0, -1, -1);
    n_cmp++; if (w_npix != 0 || w_first_valid != -1) begin
      n_err++; $display("FAIL empty_pixels: got %0d pixels first_valid=%0d expected 0 -1", w_npix, w_first_valid);
    end
    n_cmp++; if (w_ndone != 1) begin n_err++; $display("FAIL empty_done: got %0d pulses expected 1", w_ndone); end
    n_cmp++; if (w_done_cyc < 1 || w_done_cyc > NL + 2) begin
      n_err++; $display("FAIL empty_done_latency: got cycle %0d expected <= %0d", w_done_cyc, NL + 2);
    end
  endtask

  task automatic test_backpressure;
    watch_fill(5'b11111, 9'h1FF, 1, 1, 0, -1, -1);
    n_cmp++; if (w_timeout) begin n_err++; $display("FAIL bp_timeout: got timeout expected completion"); end
    n_cmp++; if (w_npix != NL * LANE_PIX) begin n_err++; $display("FAIL bp_count: got %0d expected %0d", w_npix, NL * LANE_PIX); end
    n_cmp++; if (w_nbad != 0) begin n_err++; $display("FAIL bp_sequence: got %0d bad pixels expected 0", w_nbad); end
    n_cmp++; if (w_ndone != 1) begin n_err++; $display("FAIL bp_done: got %0d pulses expected 1", w_ndone); end
  endtask

  task automatic test_abort;
    watch_fill(5'b11111, 9'h1FF, 1, 0, 0, 1000, -1);
    n_cmp++; if (w_npix != 1000) begin n_err++; $display("FAIL abort_count: got %0d expected 1000", w_npix); end
    n_cmp++; if (w_valid_end !== 1'b0 || w_extra_valid != 0) begin
      n_err++; $display("FAIL abort_valid_drop: got valid=%b extra=%0d expected 0 0", w_valid_end, w_extra_valid);
    end
    n_cmp++; if (w_ndone != 0) begin n_err++; $display("FAIL abort_no_done: got %0d pulses expected 0", w_ndone); end
    n_cmp++; if (w_nbad != 0) begin n_err++; $display("FAIL abort_sequence: got %0d bad pixels expected 0", w_nbad); end
    watch_fill(5'b11111, 9'h007, 1, 0, 0, -1, -1);
    n_cmp++; if (w_npix != NL * LANE_PIX || w_nbad != 0) begin
      n_err++; $display("FAIL abort_refill: got %0d pixels %0d bad expected %0d 0", w_npix, w_nbad, NL * LANE_PIX);
    end
    n_cmp++; if (w_ndone != 1) begin n_err++; $display("FAIL abort_refill_done: got %0d pulses expected 1", w_ndone); end
  endtask

  task automatic test_idle_abort;
    abort = 1'b1;
    @(negedge Clock);
    abort = 1'b0;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL idle_abort: got busy=%b done=%b expected 0 0", busy, done);
    end
    watch_fill(5'b00001, 9'h055, 1, 0, 1, -1, -1);
    n_cmp++; if (w_npix != LANE_PIX || w_nbad != 0) begin
      n_err++; $display("FAIL start_beats_abort: got %0d pixels %0d bad expected %0d 0", w_npix, w_nbad, LANE_PIX);
    end
    n_cmp++; if (w_ndone != 1) begin n_err++; $display("FAIL start_beats_abort_done: got %0d expected 1", w_ndone); end
  endtask

  task automatic test_async_reset;
    start = 1'b1; lane_mask = 5'b11111; fill_color = 9'h1FF;
    @(negedge Clock);
    start = 1'b0;
    repeat (20) @(negedge Clock);
    n_cmp++; if (pix_valid !== 1'b1 || pix_x === 10'd0) begin
      n_err++; $display("FAIL pre_reset_fill: got valid=%b x=%0d expected 1 nonzero", pix_valid, pix_x);
    end
    #2 Reset = 1'b1;
    #1;
    n_cmp++; if ({busy, done, pix_valid, pix_x, pix_y, pix_color} !== '0) begin
      n_err++; $display("FAIL async_reset: got busy=%b done=%b valid=%b x=%0d y=%0d c=%h expected all 0",
                        busy, done, pix_valid, pix_x, pix_y, pix_color);
    end
    @(negedge Clock);
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    n_cmp++; if (busy !== 1'b0 || pix_valid !== 1'b0) begin
      n_err++; $display("FAIL post_reset_idle: got busy=%b valid=%b expected 0 0", busy, pix_valid);
    end
  endtask

  task automatic test_autostart;
    start = 1'b1; lane_mask = 5'b00001; fill_color = 9'h1FF;
    watch_fill(5'b11111, 9'h000, 0, 0, 0, -1, 500);
    n_cmp++; if (w_first_valid != 2) begin n_err++; $display("FAIL auto_first_valid: got cycle %0d expected 2", w_first_valid); end
    n_cmp++; if (w_npix != NL * LANE_PIX) begin n_err++; $display("FAIL auto_count: got %0d expected %0d", w_npix, NL * LANE_PIX); end
    n_cmp++; if (w_nbad != 0) begin n_err++; $display("FAIL auto_sequence: got %0d bad pixels expected 0", w_nbad); end
    n_cmp++; if (w_ndone != 1) begin n_err++; $display("FAIL auto_done: got %0d pulses expected 1", w_ndone); end
  endtask

  initial begin
    test_reset;
`ifdef LANE_FILLER_AUTOSTART_EN
    test_autostart;
`else
    test_full_fill;
    test_single_lane;
    test_empty_mask;
    test_backpressure;
    test_abort;
    test_idle_abort;
    test_async_reset;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
